// File: rtl/tetris_pkg.sv
// Shared scan codes, decoder states and key indices for the PS/2 keyboard front end.
package tetris_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ROT   = 8'h75;
  localparam logic [7:0] SC_DROP  = 8'h29;

  localparam int NUM_KEYS  = 5;
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_ROT   = 3;
  localparam int KEY_DROP  = 4;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;
endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: line synchronizers, 11-bit frame shifter, parity/stop check
// and a mid-frame inactivity timeout.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_clk_prev;
  logic [3:0]    r_cnt;
  logic [8:0]    r_sr;
  logic [TW-1:0] r_to;
  logic [7:0]    r_byte;
  logic          r_valid;
  logic          r_err;

  logic w_fall;
  logic w_dat;
  logic w_frame_ok;

  assign w_dat  = r_dat_s[1];
  assign w_fall = r_clk_prev & ~r_clk_s[1];
  // r_sr[8] is the parity bit; odd parity means data+parity has an odd popcount
  assign w_frame_ok = (^r_sr) & w_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_clk_prev <= 1'b1;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_to       <= '0;
      r_byte     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_clk_s    <= {r_clk_s[0], i_ps2_clk};
      r_dat_s    <= {r_dat_s[0], i_ps2_data};
      r_clk_prev <= r_clk_s[1];
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      if (w_fall) begin
        r_to <= '0;
        if (r_cnt == 4'd0) begin
          // a start bit of 1 is noise: stay idle without reporting an error
          if (!w_dat) r_cnt <= 4'd1;
        end else if (r_cnt < 4'd10) begin
          r_sr  <= {w_dat, r_sr[8:1]};
          r_cnt <= r_cnt + 4'd1;
        end else begin
          r_cnt <= '0;
          if (w_frame_ok) begin
            r_byte  <= r_sr[7:0];
            r_valid <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
      end else if (r_cnt != 4'd0) begin
        if (r_to == TW'(TIMEOUT_CYCLES)) begin
          r_cnt <= '0;
          r_to  <= '0;
          r_err <= 1'b1;
        end else begin
          r_to <= r_to + TW'(1);
        end
      end else begin
        r_to <= '0;
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_err;
endmodule

// File: rtl/ps2_keys.sv
// PS/2 keyboard to game-key levels: receives bytes and tracks make/break of the
// arrow keys and space through an E0/F0 prefix decoder.
module ps2_keys
  import tetris_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);
  logic [7:0]          w_byte;
  logic                w_valid;
  logic                w_err;
  logic                w_make;
  logic                w_ext;
  dec_state_t          r_state, w_state_nxt;
  logic [NUM_KEYS-1:0] r_keys, w_keys_nxt;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_valid),
    .o_frame_err  (w_err)
  );

  assign w_make = (r_state == DEC_IDLE) || (r_state == DEC_EXT);
  assign w_ext  = (r_state == DEC_EXT)  || (r_state == DEC_EXT_BRK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DEC_IDLE;
      r_keys  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_keys  <= w_keys_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_keys_nxt  = r_keys;
    if (w_valid) begin
      w_state_nxt = DEC_IDLE;
      if (r_state == DEC_IDLE && w_byte == SC_EXT) begin
        w_state_nxt = DEC_EXT;
      end else if (r_state == DEC_IDLE && w_byte == SC_BRK) begin
        w_state_nxt = DEC_BRK;
      end else if (r_state == DEC_EXT && w_byte == SC_BRK) begin
        w_state_nxt = DEC_EXT_BRK;
      end else if (w_ext) begin
        // arrows only exist as extended codes; a bare 6B etc. is keypad and ignored
        case (w_byte)
          SC_LEFT:  w_keys_nxt[KEY_LEFT]  = w_make;
          SC_RIGHT: w_keys_nxt[KEY_RIGHT] = w_make;
          SC_DOWN:  w_keys_nxt[KEY_DOWN]  = w_make;
          SC_ROT:   w_keys_nxt[KEY_ROT]   = w_make;
          default:  ;
        endcase
      end else if (w_byte == SC_DROP) begin
        w_keys_nxt[KEY_DROP] = w_make;
      end
    end
  end

  assign key_left   = r_keys[KEY_LEFT];
  assign key_right  = r_keys[KEY_RIGHT];
  assign key_down   = r_keys[KEY_DOWN];
  assign key_rotate = r_keys[KEY_ROT];
  assign key_drop   = r_keys[KEY_DROP];
  assign scan_valid = w_valid;
  assign scan_code  = w_byte;
  assign frame_err  = w_err;
endmodule

// File: tb/tb_ps2_keys.sv
// Directed bench for ps2_keys: bit-banged PS/2 frames with hand-computed key levels.
module tb_ps2_keys;
  localparam int TO = 200;
  localparam int H  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_left, key_right, key_down, key_rotate, key_drop;
  logic       scan_valid, frame_err;
  logic [7:0] scan_code;

  int n_vec = 0, n_bad = 0;
  int n_sv = 0, n_err = 0, n_glitch = 0;
  int sv0, err0;
  logic watch_drop = 1'b0;
  logic [4:0] keys;

  ps2_keys #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .key_rotate (key_rotate),
    .key_drop   (key_drop),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  assign keys = {key_drop, key_rotate, key_down, key_right, key_left};

  always @(negedge clk) begin
    if (scan_valid) n_sv++;
    if (frame_err) n_err++;
    if (watch_drop && !key_drop) n_glitch++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
    logic par;
    par = ~^b ^ bad;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (H) @(negedge clk); ps2_clk = 1'b0;
      repeat (H) @(negedge clk); ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad);
    send_bits(frame(b, bad), 11);
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_keys", {27'd0, keys}, 32'h0);
    chk("rst_sv", {31'd0, scan_valid}, 32'h0);
    chk("rst_err", {31'd0, frame_err}, 32'h0);
    chk("rst_code", {24'd0, scan_code}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Space make with exact latency from the stop-bit edge
    sv0 = n_sv;
    send_bits(frame(8'h29, 1'b0), 10);
    @(negedge clk); ps2_data = 1'b1;
    repeat (H) @(negedge clk); ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drop_sv_lat", {31'd0, scan_valid}, 32'h1);
    chk("drop_code", {24'd0, scan_code}, 32'h29);
    chk("drop_key_early", {31'd0, key_drop}, 32'h0);
    @(posedge clk); #1;
    chk("drop_key_lat", {31'd0, key_drop}, 32'h1);
    chk("drop_sv_pulse", {31'd0, scan_valid}, 32'h0);
    repeat (H) @(negedge clk); ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
    chk("drop_sv_once", n_sv - sv0, 1);

    // typematic repeat keeps drop high throughout
    watch_drop = 1'b1;
    send_byte(8'h29, 1'b0);
    watch_drop = 1'b0;
    chk("typematic", n_glitch, 0);

    send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
    chk("left_make", {27'd0, keys}, 32'h11);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h6B, 1'b0);
    chk("left_break", {27'd0, keys}, 32'h10);

    send_byte(8'h6B, 1'b0);
    chk("bare_6b", {27'd0, keys}, 32'h10);
    send_byte(8'hF0, 1'b0); send_byte(8'h29, 1'b0);
    chk("drop_break", {27'd0, keys}, 32'h00);

    // bad parity keeps the FSM in EXT so the next good 75 still counts as Up
    sv0 = n_sv; err0 = n_err;
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b1);
    chk("par_err", n_err - err0, 1);
    chk("par_sv", n_sv - sv0, 1);
    chk("par_keys", {27'd0, keys}, 32'h00);
    send_byte(8'h75, 1'b0);
    chk("rot_after_err", {27'd0, keys}, 32'h08);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    chk("rot_break", {27'd0, keys}, 32'h00);

    // a lone falling edge with data high is not a start bit
    err0 = n_err;
    send_bits(11'h7FF, 1);
    send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
    chk("start1_err", n_err - err0, 0);
    chk("start1_down", {27'd0, keys}, 32'h04);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h72, 1'b0);
    chk("down_break", {27'd0, keys}, 32'h00);

    err0 = n_err; sv0 = n_sv;
    send_bits(frame(8'h74, 1'b0), 5);
    repeat (TO + 50) @(negedge clk);
    chk("timeout_err", n_err - err0, 1);
    chk("timeout_sv", n_sv - sv0, 0);
    send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
    chk("right_after_to", {27'd0, keys}, 32'h02);

    sv0 = n_sv;
    send_byte(8'hE0, 1'b0);
    pulse_rst();
    chk("rst_mid_keys", {27'd0, keys}, 32'h00);
    chk("rst_mid_code", {24'd0, scan_code}, 32'h0);
    send_byte(8'h72, 1'b0);
    chk("bare_72", {27'd0, keys}, 32'h00);
    chk("bare_72_sv", n_sv - sv0, 2);
    chk("bare_72_code", {24'd0, scan_code}, 32'h72);

    // reset in the middle of a frame drops it without any pulse
    err0 = n_err; sv0 = n_sv;
    send_bits(frame(8'h29, 1'b0), 4);
    pulse_rst();
    repeat (TO + 50) @(negedge clk);
    chk("rst_frame_err", n_err - err0, 0);
    chk("rst_frame_sv", n_sv - sv0, 0);
    send_byte(8'hE1, 1'b0);
    send_byte(8'h29, 1'b0);
    chk("e1_then_drop", {27'd0, keys}, 32'h10);
    chk("e1_err", n_err - err0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_keys.md
PS2_KEYS -- requirements
Module: ps2_keys

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the idle clk cycles mid-frame before the frame is abandoned.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port ps2_clk  input  1  raw, asynchronous PS/2 clock line.
REQ-005 SHALL have port ps2_data  input  1  raw, asynchronous PS/2 data line.
REQ-006 SHALL have port key_left  output  1  level, high while Left arrow (E0 6B) is held.
REQ-007 SHALL have port key_right  output  1  level, high while Right arrow (E0 74) is held.
REQ-008 SHALL have port key_down  output  1  level, high while Down arrow (E0 72) is held.
REQ-009 SHALL have port key_rotate  output  1  level, high while Up arrow (E0 75) is held.
REQ-010 SHALL have port key_drop  output  1  level, high while Space (29) is held.
REQ-011 SHALL have port scan_valid  output  1  one-cycle pulse per accepted byte.
REQ-012 SHALL have port scan_code  output  8  last accepted byte; valid when scan_valid is high.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse per discarded frame.

Function
REQ-014 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; a falling edge is a cycle where the previous synced clk is 1 and the current synced clk is 0.
REQ-015 SHALL sample synced data on each falling edge into an 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-016 SHALL abandon the frame silently when the start bit samples 1; bit count returns to 0 and frame_err stays low.
REQ-017 SHALL, on the stop-bit edge, accept the byte only if parity is odd over data+parity and stop=1; otherwise pulse frame_err and discard the byte.
REQ-018 SHALL pulse scan_valid and update scan_code exactly 1 cycle after the stop-bit falling edge for an accepted byte.
REQ-019 SHALL run a timeout counter that clears on every falling edge and counts only while bit count is nonzero.
REQ-020 SHALL, when the timeout counter reaches TIMEOUT_CYCLES, clear the bit count and pulse frame_err; if a falling edge occurs in the same cycle, the edge wins and no timeout fires.
REQ-021 SHALL implement a decoder FSM with states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen).
REQ-022 SHALL apply these FSM transitions on each accepted byte: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any other byte returns the FSM to IDLE after the byte is processed.
REQ-023 SHALL process a code byte as follows: IDLE/EXT set the mapped key high (make); BRK/EXT_BRK set it low (break).
REQ-024 SHALL map codes only by extension: 6B/74/72/75 map only in EXT or EXT_BRK, and 29 maps only in IDLE or BRK; all other combinations are ignored, leave the keys unchanged, and return the FSM to IDLE.
REQ-025 SHALL update key_* outputs 1 cycle after scan_valid, i.e. 2 cycles after the stop-bit edge.
REQ-026 SHALL leave a key high on repeated makes (typematic) with no glitch.
REQ-027 SHALL allow any number of keys high simultaneously.
REQ-028 SHALL leave key_* and the FSM state untouched when a frame error occurs.
REQ-029 SHALL treat an E1 prefix as an unmapped byte, without error.

Reset
REQ-030 SHALL, with rst high, clear the synchronizers to 1, clear bit count, timeout counter and scan_code to 0, put the FSM in IDLE, and drive all key_*, scan_valid and frame_err to 0.
REQ-031 SHALL discard any partial frame when rst is asserted mid-frame, with no frame_err and no scan_valid.
REQ-032 SHALL begin reception with the first falling edge after rst deasserts.

Structure
REQ-033 SHALL place the scan-code localparams (E0, F0, 6B, 74, 72, 75, 29) and the decoder state enum in shared package tetris_pkg.
REQ-034 SHALL implement the synchronizer, frame shifter, parity/stop check and timeout in sub-module ps2_rx (outputs: byte, byte_valid, frame_err).
REQ-035 SHALL implement the decoder FSM and key registers in ps2_keys.

Verification
REQ-036 SHALL cover: frame 29 with parity 0 -> scan_valid once with scan_code=29, and key_drop=1 two cycles after the stop edge.
REQ-037 SHALL cover: bytes E0,6B then E0,F0,6B -> key_left rises, then falls; no other key toggles.
REQ-038 SHALL cover: byte 6B without E0, then F0,29 -> key_left stays 0 and key_drop is cleared.
REQ-039 SHALL cover: byte 75 sent with a bad parity bit -> frame_err pulses once, no scan_valid, and key_rotate stays unchanged.
REQ-040 SHALL cover: 5 bits of a frame then silence of TIMEOUT_CYCLES -> frame_err pulses once, and the next full frame E0 74 is accepted with key_right=1.
REQ-041 SHALL cover: rst pulsed between E0 and 72 -> keys stay 0 and the FSM is in IDLE, so a following 72 alone is ignored.
